// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared types and constants for the RV32 pipeline hazard
//               sequencer and its load-use detector.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    // Sequencer state: normal flow, or parked behind a multi-cycle EX op
    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_MC_WAIT = 1'b1
    } hz_state_e;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : rv32_hazard_detect
// Description : Purely combinational load-use comparator. Flags when the load
//               currently in EX writes a register the ID instruction reads.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_hazard_detect
    import rv32_pkg::*;
(
    input  logic [4:0] i_ifid_rs1,
    input  logic [4:0] i_ifid_rs2,
    input  logic       i_ifid_use_rs1,
    input  logic       i_ifid_use_rs2,
    input  logic       i_idex_memread,
    input  logic [4:0] i_idex_rd,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // Forwarding cannot supply load data one stage early, so any real
    // source match against a load destination must stall
    always_comb begin
        w_rs1_hit  = i_ifid_use_rs1 && (i_idex_rd == i_ifid_rs1);
        w_rs2_hit  = i_ifid_use_rs2 && (i_idex_rd == i_ifid_rs2);
        o_load_use = i_idex_memread && (i_idex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);
    end

endmodule : rv32_hazard_detect
`default_nettype wire

// File: rtl/rv32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32_hazard_ctrl
// Description : Central 5-stage pipeline sequencer. Produces all stage
//               enables and flushes from memory wait, multi-cycle EX op,
//               EX redirect and load-use hazards. Also carries a memory
//               timeout watchdog and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             ex_redirect,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             stall_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             mc_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wait counter only needs to reach MEM_TIMEOUT, where it saturates
    localparam int                    c_wait_w   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0]   c_wait_max = c_wait_w'(MEM_TIMEOUT);

    hz_state_e           r_state;
    hz_state_e           w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_cnt_nxt;
    logic                r_mem_timeout;
    logic                w_mem_timeout_nxt;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    w_stall_cycles_nxt;

    logic w_mstall;
    logic w_load_use;
    logic w_mc_hold;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;
    logic w_memwb_bubble;

    rv32_hazard_detect u_detect (
        .i_ifid_rs1     (ifid_rs1),
        .i_ifid_rs2     (ifid_rs2),
        .i_ifid_use_rs1 (ifid_use_rs1),
        .i_ifid_use_rs2 (ifid_use_rs2),
        .i_idex_memread (idex_memread),
        .i_idex_rd      (idex_rd),
        .o_load_use     (w_load_use)
    );

    assign w_mstall  = dmem_req && !dmem_ready;
    // Multi-cycle op holds EX either on its first cycle in RUN or while
    // already parked; a result that is ready on arrival needs no hold
    assign w_mc_hold = !mc_done && (mc_start || (r_state == HZ_MC_WAIT));

    // Prioritised stage control and next FSM state
    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_idex_en      = 1'b1;
        w_exmem_en     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_flush  = 1'b0;
        w_memwb_bubble = 1'b0;
        w_state_nxt    = r_state;

        if (w_mstall) begin
            // Whole pipe freezes; MEM result is not valid so WB gets a NOP
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_idex_en      = 1'b0;
            w_exmem_en     = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (w_mc_hold) begin
            // Front end holds; EX/MEM keeps advancing with bubbles so older
            // instructions drain while the multi-cycle unit works
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
            w_state_nxt   = HZ_MC_WAIT;
        end else if (r_state == HZ_MC_WAIT) begin
            // Result arrived: release everything this cycle
            w_state_nxt = HZ_RUN;
        end else if (ex_redirect) begin
            // Wrong-path IF and ID instructions are squashed, which also
            // makes any load-use against the ID instruction irrelevant
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end
    end

    // Watchdog counter, sticky timeout flag and stall statistics
    always_comb begin
        w_wait_cnt_nxt = '0;
        if (w_mstall) begin
            if (r_wait_cnt != c_wait_max) begin
                w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt;
            end
        end

        w_mem_timeout_nxt = r_mem_timeout || (w_wait_cnt_nxt == c_wait_max);

        w_stall_cycles_nxt = r_stall_cycles;
        if (stall_clr) begin
            w_stall_cycles_nxt = '0;
        end else if (!w_pc_en && !(&r_stall_cycles)) begin
            w_stall_cycles_nxt = r_stall_cycles + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= HZ_RUN;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_mem_timeout  <= w_mem_timeout_nxt;
            r_stall_cycles <= w_stall_cycles_nxt;
        end
    end

    // While reset is asserted the pipe is released regardless of inputs
    assign pc_en        = w_pc_en    || !rst_n;
    assign ifid_en      = w_ifid_en  || !rst_n;
    assign idex_en      = w_idex_en  || !rst_n;
    assign exmem_en     = w_exmem_en || !rst_n;
    assign ifid_flush   = w_ifid_flush   && rst_n;
    assign idex_flush   = w_idex_flush   && rst_n;
    assign exmem_flush  = w_exmem_flush  && rst_n;
    assign memwb_bubble = w_memwb_bubble && rst_n;
    assign mc_busy      = (r_state == HZ_MC_WAIT);
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule : rv32_hazard_ctrl
`default_nettype wire

// File: tb/tb_rv32_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_hazard_ctrl
// Description : Self-checking bench for rv32_hazard_ctrl. A rule-level model
//               predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_hazard_ctrl;

    localparam int MEM_TO = 4;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [4:0]    ifid_rs1, ifid_rs2;
    logic          ifid_use_rs1, ifid_use_rs2;
    logic          idex_memread;
    logic [4:0]    idex_rd;
    logic          ex_redirect, mc_start, mc_done;
    logic          dmem_req, dmem_ready, stall_clr;
    logic          pc_en, ifid_en, idex_en, exmem_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_bubble;
    logic          mc_busy, mem_timeout;
    logic [CW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    rv32_hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .ifid_use_rs1 (ifid_use_rs1),
        .ifid_use_rs2 (ifid_use_rs2),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .ex_redirect  (ex_redirect),
        .mc_start     (mc_start),
        .mc_done      (mc_done),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .stall_clr    (stall_clr),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .memwb_bubble (memwb_bubble),
        .mc_busy      (mc_busy),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- rule-level reference model ----------------
    bit m_wait;
    int m_wcnt;
    bit m_tmo;
    int m_stall;
    bit e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_exf, e_bub;
    bit mst, lu;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_wait = 0; m_wcnt = 0; m_tmo = 0; m_stall = 0;
            chk("m_rst_pc_en",    pc_en,        1);
            chk("m_rst_exmem_en", exmem_en,     1);
            chk("m_rst_idex_fl",  idex_flush,   0);
            chk("m_rst_bubble",   memwb_bubble, 0);
            chk("m_rst_busy",     mc_busy,      0);
            chk("m_rst_cnt",      stall_cycles, 0);
        end else begin
            mst = dmem_req && !dmem_ready;
            lu  = idex_memread && (idex_rd != 0) &&
                  ((idex_rd == ifid_rs1 && ifid_use_rs1) || (idex_rd == ifid_rs2 && ifid_use_rs2));
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
            {e_iff, e_idf, e_exf, e_bub}    = 4'b0000;
            if (mst) begin
                {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
                e_bub = 1;
            end else if ((m_wait || mc_start) && !mc_done) begin
                {e_pc, e_ifid, e_idex} = 3'b000;
                e_exf = 1;
            end else if (!m_wait && ex_redirect) begin
                e_iff = 1; e_idf = 1;
            end else if (!m_wait && lu) begin
                e_pc = 0; e_ifid = 0; e_idf = 1;
            end
            chk("m_pc_en",       pc_en,        e_pc);
            chk("m_ifid_en",     ifid_en,      e_ifid);
            chk("m_idex_en",     idex_en,      e_idex);
            chk("m_exmem_en",    exmem_en,     e_exmem);
            chk("m_ifid_flush",  ifid_flush,   e_iff);
            chk("m_idex_flush",  idex_flush,   e_idf);
            chk("m_exmem_flush", exmem_flush,  e_exf);
            chk("m_bubble",      memwb_bubble, e_bub);
            chk("m_mc_busy",     mc_busy,      m_wait);
            chk("m_timeout",     mem_timeout,  m_tmo);
            chk("m_stall_cnt",   stall_cycles, m_stall);
            // advance model to the state after the coming rising edge
            if (mst) m_wcnt = (m_wcnt < MEM_TO) ? m_wcnt + 1 : m_wcnt;
            else     m_wcnt = 0;
            if (m_wcnt >= MEM_TO) m_tmo = 1;
            if (stall_clr)                 m_stall = 0;
            else if (!e_pc && m_stall < CMAX) m_stall = m_stall + 1;
            if (!mst) m_wait = mc_done ? 1'b0 : (m_wait || mc_start);
        end
    end

    // Redirect together with a multi-cycle start is an illegal input combination
    always @(negedge clk) begin
        if (rst_n) assert (!(ex_redirect && mc_start)) else $error("illegal ex_redirect with mc_start");
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
        idex_memread = 0; idex_rd = 0; ex_redirect = 0;
        mc_start = 0; mc_done = 0; dmem_req = 0; dmem_ready = 1; stall_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_en",   pc_en,        1);
        chk("rst_busy",    mc_busy,      0);
        chk("rst_cnt",     stall_cycles, 0);
        rst_n = 1'b1;

        // Load-use on rs2: one stall cycle
        idex_memread = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
        mid();
        chk("lu_pc_en",      pc_en,      0);
        chk("lu_ifid_en",    ifid_en,    0);
        chk("lu_idex_flush", idex_flush, 1);
        tick(); idle();
        mid();
        chk("lu_after_pc_en", pc_en,        1);
        chk("lu_after_cnt",   stall_cycles, 1);
        tick();
        // Load to x0 never stalls
        idex_memread = 1; idex_rd = 0; ifid_rs2 = 0; ifid_use_rs2 = 1;
        mid();
        chk("lu_x0_pc_en", pc_en,      1);
        chk("lu_x0_flush", idex_flush, 0);
        tick(); idle();
        // rs1 matches but is not read
        idex_memread = 1; idex_rd = 7; ifid_rs1 = 7;
        mid();
        chk("lu_unused_pc_en", pc_en, 1);
        tick(); idle();
        stall_clr = 1;
        tick(); idle();
        mid();
        chk("clr_cnt", stall_cycles, 0);
        tick();

        // Multi-cycle op: done rises 4 cycles after start
        mc_start = 1;
        mid();
        chk("mc0_pc_en", pc_en,       0);
        chk("mc0_exfl",  exmem_flush, 1);
        chk("mc0_busy",  mc_busy,     0);
        tick();
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("mcw_busy", mc_busy,     1);
            chk("mcw_exfl", exmem_flush, 1);
            tick();
        end
        mc_done = 1;
        mid();
        chk("mcd_busy",  mc_busy,     1);
        chk("mcd_pc_en", pc_en,       1);
        chk("mcd_exfl",  exmem_flush, 0);
        tick(); idle();
        mid();
        chk("mc_end_busy", mc_busy,      0);
        chk("mc_end_cnt",  stall_cycles, 4);
        tick();
        // Start and done together: no stall
        mc_start = 1; mc_done = 1;
        mid();
        chk("mc_same_pc_en", pc_en,       1);
        chk("mc_same_exfl",  exmem_flush, 0);
        tick(); idle();
        mid();
        chk("mc_same_busy", mc_busy, 0);
        tick();

        // Redirect beats load-use
        ex_redirect = 1; idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
        mid();
        chk("rd_ifid_fl", ifid_flush, 1);
        chk("rd_idex_fl", idex_flush, 1);
        chk("rd_pc_en",   pc_en,      1);
        chk("rd_ifid_en", ifid_en,    1);
        tick(); idle();

        // Memory stall while parked in MC_WAIT with the result ready
        mc_start = 1;
        tick();
        mc_done = 1; dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("ms_exmem_en", exmem_en,     0);
            chk("ms_bubble",   memwb_bubble, 1);
            chk("ms_busy",     mc_busy,      1);
            tick();
        end
        dmem_ready = 1;
        mid();
        chk("ms_rel_busy",  mc_busy,      1);
        chk("ms_rel_exen",  exmem_en,     1);
        chk("ms_rel_bub",   memwb_bubble, 0);
        tick(); idle();
        mid();
        chk("ms_exit_busy", mc_busy,      0);
        chk("ms_exit_cnt",  stall_cycles, 8);
        chk("ms_exit_tmo",  mem_timeout,  0);
        tick();

        // Watchdog: timeout after 4 consecutive wait cycles, then sticky
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < MEM_TO; i++) begin
            mid();
            chk("wd_pre_tmo", mem_timeout, 0);
            tick();
        end
        mid();
        chk("wd_tmo",     mem_timeout,  1);
        chk("wd_cnt12",   stall_cycles, 12);
        repeat (5) tick();
        mid();
        chk("wd_cnt_sat", stall_cycles, CMAX);
        tick();
        dmem_ready = 1;
        mid();
        chk("wd_ready_tmo", mem_timeout, 1);
        chk("wd_ready_pc",  pc_en,       1);
        tick(); idle();
        mid();
        chk("wd_sticky",  mem_timeout,  1);
        chk("wd_sat_hold", stall_cycles, CMAX);
        tick();
        // Clear wins over a simultaneous increment
        dmem_req = 1; dmem_ready = 0; stall_clr = 1;
        tick(); idle();
        mid();
        chk("clr_prio_cnt", stall_cycles, 0);
        tick();

        // Asynchronous reset while in MC_WAIT
        mc_start = 1;
        tick();
        mid();
        chk("ar_pre_busy", mc_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy",   mc_busy,      0);
        chk("ar_pc_en",  pc_en,        1);
        chk("ar_ifid",   ifid_en,      1);
        chk("ar_exfl",   exmem_flush,  0);
        chk("ar_cnt",    stall_cycles, 0);
        chk("ar_tmo",    mem_timeout,  0);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        mid();
        chk("ar_post_busy", mc_busy, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rv32_hazard_ctrl
`default_nettype wire
